// File: rtl/morse_encoder_seq.sv
// morse_encoder_seq: FIFO-fed Morse encoder sending letters back-to-back with unit-accurate timing.
// Rev 1.0
`default_nettype none

module morse_encoder_seq #(
  parameter int UNIT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [2:0]                   LetterIn,
  input  logic                         LetterValid,
  output logic                         LetterReady,
  input  logic                         Abort,
  output logic [1:0]                   Morse,
  output logic                         KeyOut,
  output logic                         Busy,
  output logic [3:0]                   State,
  output logic [$clog2(FIFO_DEPTH):0]  Count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(4 * UNIT_CYCLES);

  localparam logic [CW-1:0] LOAD_DOT  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_DASH = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_WGAP = CW'(4 * UNIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_MARK   = 4'd2,
    S_ESPACE = 4'd3,
    S_LGAP   = 4'd4,
    S_WGAP   = 4'd5
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     unit_cnt, cnt_nx;
  logic [3:0]        pat, pat_nx;
  logic [2:0]        len, len_nx;
  logic [1:0]        rem, rem_nx;
  logic [1:0]        morse_nx;
  logic              key_nx;
  logic              timer_done;

  logic [2:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [2:0]        head;
  logic              push, pop;

  assign LetterReady = (Count != CNT_W'(FIFO_DEPTH));
  assign Busy        = (state != S_IDLE) || (Count != '0);
  assign State       = state;
  assign head        = mem[rd_ptr];
  assign timer_done  = (unit_cnt == '0);

  // Code 7 completes the handshake but never reaches the queue.
  assign push = LetterValid && LetterReady && !Abort && (LetterIn != 3'd7);

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= LetterIn;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else if (Abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      unit_cnt <= '0;
      pat      <= '0;
      len      <= '0;
      rem      <= '0;
      Morse    <= 2'b00;
      KeyOut   <= 1'b0;
    end else begin
      state    <= state_nx;
      unit_cnt <= cnt_nx;
      pat      <= pat_nx;
      len      <= len_nx;
      rem      <= rem_nx;
      Morse    <= morse_nx;
      KeyOut   <= key_nx;
    end
  end

  // Pattern bit 0 is the element about to be sent (1 = dash); it shifts right per element.
  always_comb begin
    state_nx = state;
    cnt_nx   = timer_done ? unit_cnt : unit_cnt - 1'b1;
    pat_nx   = pat;
    len_nx   = len;
    rem_nx   = rem;
    morse_nx = Morse;
    key_nx   = KeyOut;
    pop      = 1'b0;

    if (Abort) begin
      state_nx = S_IDLE;
      morse_nx = 2'b00;
      key_nx   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Count != '0) begin
            pop      = 1'b1;
            state_nx = S_LOAD;
            case (head)
              3'd0:    begin len_nx = 3'd4; pat_nx = 4'b0000; end
              3'd1:    begin len_nx = 3'd1; pat_nx = 4'b0000; end
              3'd2:    begin len_nx = 3'd4; pat_nx = 4'b0010; end
              3'd3:    begin len_nx = 3'd3; pat_nx = 4'b0111; end
              3'd5:    begin len_nx = 3'd3; pat_nx = 4'b0000; end
              3'd6:    begin len_nx = 3'd1; pat_nx = 4'b0001; end
              default: begin len_nx = 3'd0; pat_nx = 4'b0000; end
            endcase
          end
        end
        S_LOAD: begin
          if (len == 3'd0) begin
            state_nx = S_WGAP;
            cnt_nx   = LOAD_WGAP;
          end else begin
            state_nx = S_MARK;
            morse_nx = pat[0] ? 2'b10 : 2'b01;
            key_nx   = 1'b1;
            cnt_nx   = pat[0] ? LOAD_DASH : LOAD_DOT;
            pat_nx   = pat >> 1;
            rem_nx   = 2'(len - 3'd1);
          end
        end
        S_MARK: begin
          if (timer_done) begin
            morse_nx = 2'b00;
            key_nx   = 1'b0;
            if (rem != 2'd0) begin
              state_nx = S_ESPACE;
              cnt_nx   = LOAD_DOT;
            end else begin
              state_nx = S_LGAP;
              cnt_nx   = LOAD_DASH;
            end
          end
        end
        S_ESPACE: begin
          if (timer_done) begin
            state_nx = S_MARK;
            morse_nx = pat[0] ? 2'b10 : 2'b01;
            key_nx   = 1'b1;
            cnt_nx   = pat[0] ? LOAD_DASH : LOAD_DOT;
            pat_nx   = pat >> 1;
            rem_nx   = rem - 1'b1;
          end
        end
        S_LGAP, S_WGAP: begin
          if (timer_done) state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
          morse_nx = 2'b00;
          key_nx   = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder_seq.sv
// Testbench for morse_encoder_seq: directed and random letter sequences against a waveform model.
`default_nettype none

module tb_morse_encoder_seq;

  localparam int U = 2;
  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] LetterIn;
  logic       LetterValid;
  logic       LetterReady;
  logic       Abort;
  logic [1:0] Morse;
  logic       KeyOut;
  logic       Busy;
  logic [3:0] State;
  logic [2:0] Count;

  morse_encoder_seq #(.UNIT_CYCLES(U), .FIFO_DEPTH(D)) dut (
    .Clock(Clock), .Reset(Reset), .LetterIn(LetterIn), .LetterValid(LetterValid),
    .LetterReady(LetterReady), .Abort(Abort), .Morse(Morse), .KeyOut(KeyOut),
    .Busy(Busy), .State(State), .Count(Count)
  );

  always #5 Clock = ~Clock;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  string elems[7] = '{"....", ".", ".-..", "---", "", "...", "-"};
  logic [2:0] seq[$];
  logic [1:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Expected Morse per cycle, cycle 0 being the cycle after the first letter is accepted.
  function automatic void build_model();
    expq.delete();
    foreach (seq[i]) begin
      string s = elems[seq[i]];
      expq.push_back(2'b00);
      expq.push_back(2'b00);
      for (int e = 0; e < s.len(); e++) begin
        bit dash = (s[e] == "-");
        for (int k = 0; k < (dash ? 3 * U : U); k++) expq.push_back(dash ? 2'b10 : 2'b01);
        if (e != s.len() - 1)
          for (int k = 0; k < U; k++) expq.push_back(2'b00);
      end
      for (int k = 0; k < ((s.len() == 0) ? 4 * U : 3 * U); k++) expq.push_back(2'b00);
    end
  endfunction

  task automatic check_cyc(input string tag, input int cyc);
    chk($sformatf("%s morse c%0d", tag, cyc), Morse, expq[cyc]);
    chk($sformatf("%s key c%0d", tag, cyc), KeyOut, (expq[cyc] != 2'b00));
    if (cyc >= 1) chk($sformatf("%s busy c%0d", tag, cyc), Busy, 1);
  endtask

  task automatic run_seq(input string tag);
    int cyc = 0;
    build_model();
    for (int i = 0; i < seq.size(); i++) begin
      chk({tag, " ready"}, LetterReady, 1);
      LetterIn    = seq[i];
      LetterValid = 1'b1;
      step();
      check_cyc(tag, cyc);
      cyc++;
    end
    LetterValid = 1'b0;
    while (cyc < expq.size()) begin
      step();
      check_cyc(tag, cyc);
      cyc++;
    end
    step();
    step();
    chk({tag, " end state"}, State, 0);
    chk({tag, " end busy"}, Busy, 0);
    chk({tag, " end count"}, Count, 0);
    chk({tag, " end morse"}, Morse, 0);
  endtask

  initial begin
    int t;
    Reset = 1'b1; LetterIn = 3'd0; LetterValid = 1'b0; Abort = 1'b0;
    step();
    step();
    chk("reset morse", Morse, 0);
    chk("reset key", KeyOut, 0);
    chk("reset busy", Busy, 0);
    chk("reset state", State, 0);
    chk("reset count", Count, 0);
    chk("reset ready", LetterReady, 1);
    Reset = 1'b0;
    step();

    seq = '{3'd1};             run_seq("E");
    seq = '{3'd3};             run_seq("O");
    seq = '{3'd1, 3'd4, 3'd6}; run_seq("E_blank_T");

    // Reserved code is acknowledged but never queued.
    chk("c7 ready", LetterReady, 1);
    LetterIn = 3'd7; LetterValid = 1'b1;
    step();
    LetterValid = 1'b0;
    chk("c7 count", Count, 0);
    chk("c7 busy", Busy, 0);
    chk("c7 morse", Morse, 0);
    step();
    chk("c7 state", State, 0);

    // Fill the queue while the encoder works on the first H.
    LetterIn = 3'd0; LetterValid = 1'b1;
    t = 0;
    while (LetterReady !== 1'b0 && t < 20) begin step(); t++; end
    chk("full count", Count, 4);
    chk("full ready", LetterReady, 0);
    t = 0;
    while (State !== 4'd1 && t < 60) begin step(); t++; end
    chk("full pop load", State, 1);
    chk("full pop count", Count, 3);
    chk("full pop ready", LetterReady, 1);
    step();
    chk("full refill count", Count, 4);
    chk("full refill ready", LetterReady, 0);
    LetterValid = 1'b0;
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("full abort count", Count, 0);
    chk("full abort state", State, 0);

    // Asynchronous reset in the middle of L's dash.
    LetterIn = 3'd2; LetterValid = 1'b1;
    step();
    LetterValid = 1'b0;
    t = 0;
    while (Morse !== 2'b10 && t < 40) begin step(); t++; end
    chk("L dash reached", Morse, 2);
    step();
    #2;
    Reset = 1'b1;
    #1;
    chk("rst morse", Morse, 0);
    chk("rst key", KeyOut, 0);
    chk("rst count", Count, 0);
    chk("rst state", State, 0);
    Reset = 1'b0;
    step();
    seq = '{3'd2}; run_seq("L_after_reset");

    // Abort during an element space with two letters queued; a same-cycle push is dropped.
    LetterIn = 3'd0; LetterValid = 1'b1; step();
    LetterIn = 3'd5; step();
    LetterIn = 3'd6; step();
    LetterValid = 1'b0;
    t = 0;
    while (State !== 4'd3 && t < 40) begin step(); t++; end
    chk("abort espace", State, 3);
    chk("abort queued", Count, 2);
    Abort = 1'b1; LetterIn = 3'd1; LetterValid = 1'b1;
    step();
    Abort = 1'b0; LetterValid = 1'b0;
    chk("abort morse", Morse, 0);
    chk("abort key", KeyOut, 0);
    chk("abort count", Count, 0);
    chk("abort state", State, 0);
    step();
    step();
    chk("abort quiet morse", Morse, 0);
    chk("abort quiet busy", Busy, 0);
    seq = '{3'd6}; run_seq("T_after_abort");

    for (int tr = 0; tr < 8; tr++) begin
      int n = $urandom_range(1, 4);
      seq.delete();
      for (int i = 0; i < n; i++) seq.push_back(3'($urandom_range(0, 6)));
      run_seq($sformatf("rand%0d", tr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
